// File: rtl/i2c_periph.sv
// i2c_periph: simplified I2C target with a fixed 7-bit address and a single 8-bit data register.
module i2c_periph #(
    parameter logic [6:0] ADDRESS     = 7'h55,
    parameter logic [7:0] RESET_DATA  = 8'h67,
    parameter logic [7:0] SDA_OE_MASK = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       read_channel,
    output logic       write_channel,
    output logic [7:0] direction
);
    typedef enum logic [3:0] {IDLE, ADDR, RW, ACK, TX, RX, MACK, SKIP, DONE, ACK_W} state_t;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d, data_q, data_d, dir_q, dir_d;
    logic       rw_q, rw_d, wc_q, wc_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        data_d  = data_q;
        rw_d    = rw_q;
        wc_d    = 1'b1;
        dir_d   = 8'h00;
        unique case (state_q)
            IDLE: if (!read_channel) begin
                state_d = ADDR;
                cnt_d   = 4'd6;
            end
            ADDR: begin
                sh_d    = {sh_q[6:0], read_channel};
                cnt_d   = cnt_q - 4'd1;
                state_d = cnt_q == 4'd0 ? RW : ADDR;
            end
            RW: begin
                rw_d = read_channel;
                if (sh_q[6:0] == ADDRESS) begin
                    state_d = ACK;
                    wc_d    = 1'b0;
                    dir_d   = SDA_OE_MASK;
                end else begin
                    state_d = SKIP;
                    cnt_d   = 4'd9;
                end
            end
            ACK: begin
                cnt_d = 4'd7;
                if (rw_q) begin
                    state_d = TX;
                    wc_d    = data_q[7];
                    dir_d   = SDA_OE_MASK;
                end else begin
                    state_d = RX;
                end
            end
            TX: if (cnt_q == 4'd0) begin
                state_d = MACK;
            end else begin
                cnt_d = cnt_q - 4'd1;
                wc_d  = data_q[cnt_q[2:0] - 3'd1];
                dir_d = SDA_OE_MASK;
            end
            RX: begin
                sh_d  = {sh_q[6:0], read_channel};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    data_d  = {sh_q[6:0], read_channel};
                    state_d = ACK_W;
                    wc_d    = 1'b0;
                    dir_d   = SDA_OE_MASK;
                end
            end
            // Controller ack/nack is observed but has no effect: single byte per transaction.
            MACK:  state_d = DONE;
            ACK_W: state_d = DONE;
            SKIP: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = cnt_q == 4'd1 ? DONE : SKIP;
            end
            DONE: state_d = read_channel ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sh_q    <= 8'h00;
            data_q  <= RESET_DATA;
            rw_q    <= 1'b0;
            wc_q    <= 1'b1;
            dir_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            rw_q    <= rw_d;
            wc_q    <= wc_d;
            dir_q   <= dir_d;
        end
    end
    assign write_channel = wc_q;
    assign direction     = dir_q;
endmodule

// File: tb/tb_i2c_periph.sv
// tb_i2c_periph: randomized frame-level bench; expected pad activity per SCL edge is queued and checked by a monitor.
module tb_i2c_periph;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       read_channel = 1'b1;
    logic       write_channel;
    logic [7:0] direction;
    logic [8:0] exp_q[$];
    logic [8:0] e;
    logic [7:0] mem;
    int         ntests = 0;
    int         nerrs = 0;

    i2c_periph dut (
        .clk(clk),
        .reset(reset),
        .read_channel(read_channel),
        .write_channel(write_channel),
        .direction(direction)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ntests++;
            if ({write_channel, direction} !== e) begin
                nerrs++;
                $display("FAIL pad @%0t: got wc=%b dir=%h, want wc=%b dir=%h",
                         $time, write_channel, direction, e[8], e[7:0]);
            end
        end
    end

    task automatic step(input logic r, input logic b, input logic ewc, input logic [7:0] ed);
        @(negedge clk);
        reset = r;
        read_channel = b;
        exp_q.push_back({ewc, ed});
    endtask

    task automatic txn(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                       input logic ack, input int abort_after);
        logic m;
        m = (a == 7'h55);
        step(1, 0, 1, 8'h00);
        for (int i = 6; i >= 0; i--) step(1, a[i], 1, 8'h00);
        step(1, rw, m ? 1'b0 : 1'b1, m ? 8'h01 : 8'h00);
        if (m && rw) begin
            for (int i = 7; i >= 0; i--) begin
                if (abort_after == 7 - i) begin
                    step(0, 1, 1, 8'h00);
                    #1;
                    ntests++;
                    if (write_channel !== 1'b1 || direction !== 8'h00) begin
                        nerrs++;
                        $display("FAIL async_reset: got wc=%b dir=%h, want wc=1 dir=00",
                                 write_channel, direction);
                    end
                    step(0, 1, 1, 8'h00);
                    step(1, 1, 1, 8'h00);
                    step(1, 1, 1, 8'h00);
                    mem = 8'h67;
                    return;
                end
                step(1, 1, mem[i], 8'h01);
            end
            step(1, 1, 1, 8'h00);
            step(1, ack, 1, 8'h00);
            step(1, 1, 1, 8'h00);
        end else if (m) begin
            step(1, 1, 1, 8'h00);
            for (int i = 7; i >= 0; i--)
                step(1, wd[i], i == 0 ? 1'b0 : 1'b1, i == 0 ? 8'h01 : 8'h00);
            mem = wd;
            step(1, 1, 1, 8'h00);
            step(1, 1, 1, 8'h00);
        end else begin
            for (int i = 0; i < 9; i++) step(1, 1'($urandom), 1, 8'h00);
            step(1, 0, 1, 8'h00);
            step(1, 1, 1, 8'h00);
            step(1, 1, 1, 8'h00);
        end
    endtask

    initial begin
        mem = 8'h67;
        for (int i = 0; i < 3; i++) step(0, 1, 1, 8'h00);
        for (int i = 0; i < 10; i++) step(1, 1, 1, 8'h00);
        txn(7'h55, 1, 8'h00, 0, -1);
        txn(7'h55, 0, 8'hA5, 0, -1);
        txn(7'h55, 1, 8'h00, 0, -1);
        txn(7'h2A, 1, 8'h00, 0, -1);
        txn(7'h55, 1, 8'h00, 0, -1);
        txn(7'h55, 0, 8'h3C, 0, -1);
        txn(7'h55, 1, 8'h00, 0, 3);
        txn(7'h55, 1, 8'h00, 0, -1);
        txn(7'h55, 1, 8'h00, 1, -1);
        txn(7'h55, 1, 8'h00, 0, -1);
        for (int n = 0; n < 60; n++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h55;
            txn(a, 1'($urandom), 8'($urandom), 1'($urandom),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1);
            repeat ($urandom_range(0, 3)) step(1, 1, 1, 8'h00);
        end
        txn(7'h55, 1, 8'h00, 0, -1);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        ntests++;
        if (exp_q.size() != 0) begin
            nerrs++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nerrs);
        $finish;
    end
endmodule
